// File: rtl/sti_receiver_if.sv
// Serial-in / parallel-out bus bundle for sti_receiver: serial frame input,
// configuration strobes and the recovered word outputs.
interface sti_receiver_if;
    logic        si_data;
    logic        si_valid;
    logic [1:0]  cfg_length;
    logic        cfg_msb;
    logic        cfg_fill;
    logic        cfg_low;
    logic [15:0] po_data;
    logic        po_valid;
    logic        po_err;
    logic [7:0]  frame_cnt;

    modport master (
        output si_data, si_valid, cfg_length, cfg_msb, cfg_fill, cfg_low,
        input  po_data, po_valid, po_err, frame_cnt
    );

    modport slave (
        input  si_data, si_valid, cfg_length, cfg_msb, cfg_fill, cfg_low,
        output po_data, po_valid, po_err, frame_cnt
    );
endinterface

// File: rtl/sti_receiver.sv
// Serial frame receiver: shifts in 8/16/24/32-bit frames and emits a 16-bit word.
// Optional frame length checking is enabled by defining STI_RECEIVER_LEN_CHECK_EN.
module sti_receiver (
    input  logic           clk,
    input  logic           reset,
    sti_receiver_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  len_q, len_d;
    logic        msb_q, msb_d;
    logic        fill_q, fill_d;
    logic        low_q, low_d;
    logic [15:0] po_data_q, po_data_d;
    logic        po_valid_q, po_valid_d;
    logic        po_err_q, po_err_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;

    logic [7:0]  rev8;
    logic [15:0] rev16;
    logic [23:0] rev24;
    logic [31:0] rev32;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [23:0] d24;
    logic [31:0] d32;
    logic [15:0] word;
    logic        start;

    // First received bit lands at F[N-1]; LSB-first frames need an N-bit reversal.
    always_comb begin
        rev8  = '0;
        rev16 = '0;
        rev24 = '0;
        rev32 = '0;
        for (int i = 0; i < 8; i++)  rev8[i]  = shift_q[7 - i];
        for (int i = 0; i < 16; i++) rev16[i] = shift_q[15 - i];
        for (int i = 0; i < 24; i++) rev24[i] = shift_q[23 - i];
        for (int i = 0; i < 32; i++) rev32[i] = shift_q[31 - i];
    end

    always_comb begin
        d8   = msb_q ? shift_q[7:0]  : rev8;
        d16  = msb_q ? shift_q[15:0] : rev16;
        d24  = msb_q ? shift_q[23:0] : rev24;
        d32  = msb_q ? shift_q[31:0] : rev32;
        word = '0;
        case (len_q)
            2'd0:    word = low_q  ? {d8, 8'h00} : {8'h00, d8};
            2'd1:    word = d16;
            2'd2:    word = fill_q ? d24[23:8]  : d24[15:0];
            default: word = fill_q ? d32[31:16] : d32[15:0];
        endcase
    end

`ifdef STI_RECEIVER_LEN_CHECK_EN
    logic [5:0] expBits;
    logic       lenOk;

    always_comb begin
        expBits = {({1'b0, len_q} + 3'd1), 3'b000};
        lenOk   = (cnt_q == expBits);
    end
`endif

    // A new frame may begin from IDLE or directly in the DONE cycle.
    assign start = bus.si_valid && (state_q != RECV);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        msb_d       = msb_q;
        fill_d      = fill_q;
        low_d       = low_q;
        po_data_d   = po_data_q;
        po_valid_d  = 1'b0;
        po_err_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;

        if (start) begin
            state_d = RECV;
            shift_d = {31'd0, bus.si_data};
            cnt_d   = 6'd1;
            len_d   = bus.cfg_length;
            msb_d   = bus.cfg_msb;
            fill_d  = bus.cfg_fill;
            low_d   = bus.cfg_low;
        end else begin
            case (state_q)
                RECV: begin
                    if (bus.si_valid) begin
                        shift_d = {shift_q[30:0], bus.si_data};
                        cnt_d   = (cnt_q == 6'd33) ? cnt_q : cnt_q + 6'd1;
                    end else begin
                        state_d = DONE;
`ifdef STI_RECEIVER_LEN_CHECK_EN
                        if (!lenOk) begin
                            po_err_d = 1'b1;
                        end else begin
                            po_valid_d  = 1'b1;
                            po_data_d   = word;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                        end
`else
                        po_valid_d  = 1'b1;
                        po_data_d   = word;
                        frame_cnt_d = frame_cnt_q + 8'd1;
`endif
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            msb_q       <= 1'b0;
            fill_q      <= 1'b0;
            low_q       <= 1'b0;
            po_data_q   <= '0;
            po_valid_q  <= 1'b0;
            po_err_q    <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            msb_q       <= msb_d;
            fill_q      <= fill_d;
            low_q       <= low_d;
            po_data_q   <= po_data_d;
            po_valid_q  <= po_valid_d;
            po_err_q    <= po_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.po_data   = po_data_q;
    assign bus.po_valid  = po_valid_q;
    assign bus.po_err    = po_err_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sti_receiver.sv
// Scoreboard bench for sti_receiver: directed frames push expected words,
// a negedge monitor pops and compares on every po_valid/po_err pulse.
module tb_sti_receiver;

    logic clk;
    logic reset;

    sti_receiver_if bus ();

    sti_receiver dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        isErr;
        logic [15:0] data;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  expCnt = 8'd0;
    logic [15:0] expData = 16'd0;
    logic [15:0] lastData = 16'd0;
    logic        prevPulse = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: compares each output pulse against the scoreboard and checks po_data holds otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            lastData  = 16'd0;
            prevPulse = 1'b0;
        end else begin
            if (bus.po_valid || bus.po_err) begin
                checkOutput("single_cycle_pulse", {31'd0, prevPulse}, 32'd0);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", {30'd0, bus.po_valid, bus.po_err}, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("po_valid", {31'd0, bus.po_valid}, {31'd0, !e.isErr});
                    checkOutput("po_err", {31'd0, bus.po_err}, {31'd0, e.isErr});
                    checkOutput("po_data", {16'd0, bus.po_data}, {16'd0, e.data});
                    checkOutput("frame_cnt", {24'd0, bus.frame_cnt}, {24'd0, e.cnt});
                    lastData = e.data;
                end
            end else begin
                checkOutput("po_data_hold", {16'd0, bus.po_data}, {16'd0, lastData});
            end
            prevPulse = bus.po_valid || bus.po_err;
        end
    end

    // Sends nbits of order, order[nbits-1] first; cfg is scrambled after the first bit.
    task automatic applyStimulus(input logic [1:0] len, input logic msb, input logic fill,
                                 input logic low, input logic [31:0] order, input int nbits,
                                 input logic isErr, input logic [15:0] want);
        exp_t e;
        if (!isErr) begin
            expCnt  = expCnt + 8'd1;
            expData = want;
        end
        e.isErr = isErr;
        e.data  = expData;
        e.cnt   = expCnt;
        expQ.push_back(e);
        bus.cfg_length = len;
        bus.cfg_msb    = msb;
        bus.cfg_fill   = fill;
        bus.cfg_low    = low;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.si_valid = 1'b1;
            bus.si_data  = order[i];
            @(posedge clk);
            #1;
            bus.cfg_length = ~len;
            bus.cfg_msb    = ~msb;
            bus.cfg_fill   = ~fill;
            bus.cfg_low    = ~low;
        end
        bus.si_valid = 1'b0;
        bus.si_data  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        if (expQ.size() != 0) begin
            checkOutput("drain_timeout", expQ.size(), 32'd0);
            expQ.delete();
        end
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.si_valid = 1'b0;
        bus.si_data  = 1'b0;
        expCnt       = 8'd0;
        expData      = 16'd0;
    endtask

    initial begin
        reset          = 1'b1;
        bus.si_data    = 1'b0;
        bus.si_valid   = 1'b0;
        bus.cfg_length = 2'd0;
        bus.cfg_msb    = 1'b0;
        bus.cfg_fill   = 1'b0;
        bus.cfg_low    = 1'b0;
        doReset(3);
        #1;
        checkOutput("reset_po_data", {16'd0, bus.po_data}, 32'd0);
        checkOutput("reset_po_valid", {31'd0, bus.po_valid}, 32'd0);
        checkOutput("reset_po_err", {31'd0, bus.po_err}, 32'd0);
        checkOutput("reset_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_A5C3, 16, 1'b0, 16'hA5C3);
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_003C, 8, 1'b0, 16'h003C);
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b1, 32'h0000_003C, 8, 1'b0, 16'h3C00);
        applyStimulus(2'd0, 1'b0, 1'b0, 1'b0, 32'h0000_0085, 8, 1'b0, 16'h00A1);
        applyStimulus(2'd3, 1'b1, 1'b0, 1'b0, 32'hABCD_1234, 32, 1'b0, 16'h1234);
        applyStimulus(2'd3, 1'b1, 1'b1, 1'b0, 32'h1234_ABCD, 32, 1'b0, 16'h1234);
        applyStimulus(2'd2, 1'b0, 1'b1, 1'b0, 32'h0000_F77D, 24, 1'b0, 16'hBEEF);
        applyStimulus(2'd2, 1'b1, 1'b0, 1'b0, 32'h00AB_1234, 24, 1'b0, 16'h1234);
`ifdef STI_RECEIVER_LEN_CHECK_EN
        applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 12, 1'b1, 16'h0000);
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_03A5, 10, 1'b1, 16'h0000);
`else
        applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0ABC, 12, 1'b0, 16'h0ABC);
        applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 32'h0000_03A5, 10, 1'b0, 16'h00A5);
`endif
        applyStimulus(2'd1, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 16, 1'b0, 16'h8000);
        waitDrain();

        bus.cfg_length = 2'd1;
        bus.cfg_msb    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.si_valid = 1'b1;
            bus.si_data  = i[0];
            @(posedge clk);
            #1;
        end
        doReset(2);
        #1;
        checkOutput("midframe_reset_frame_cnt", {24'd0, bus.frame_cnt}, 32'd0);
        checkOutput("midframe_reset_po_data", {16'd0, bus.po_data}, 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000_0F0F, 16, 1'b0, 16'h0F0F);
        waitDrain();

        doReset(2);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i) ^ 8'hA5;
            applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, {24'd0, v}, 8, 1'b0, {8'h00, v});
        end
        waitDrain();
        checkOutput("frame_cnt_wrap", {24'd0, bus.frame_cnt}, 32'd0);
        checkOutput("final_po_data", {16'd0, bus.po_data}, 32'h0000_005A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
